// File: rtl/decimate_pkg.sv
// Shared constants for the decimate CIC filter: default ratio, CIC order,
// internal width/shift helpers and output saturation limits.
package decimate_pkg;

  localparam int DECIM_DEFAULT = 64;
  localparam int CIC_ORDER     = 3;
  localparam int OUT_W         = 15;
  localparam int SAT_MAX       = 16383;
  localparam int SAT_MIN       = -16384;

  typedef logic signed [OUT_W-1:0] sample_t;

  // Bit growth of an order-3 CIC is 3*log2(R); two extra bits cover the +/-1 input.
  function automatic int cic_width(input int decim);
    return 2 + CIC_ORDER * $clog2(decim);
  endfunction

  function automatic int cic_shift(input int decim);
    return CIC_ORDER * $clog2(decim) - (OUT_W - 1);
  endfunction

  localparam int W_DEFAULT = cic_width(DECIM_DEFAULT);
  localparam int S_DEFAULT = cic_shift(DECIM_DEFAULT);

endpackage

// File: rtl/decimate_comb.sv
// One CIC comb stage: on each enable, output the input minus the input
// seen at the previous enable; valid follows enable by one cycle.
module decimate_comb
  import decimate_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] dout,
  output logic                valid
);

  logic signed [W-1:0] dout_q, dout_d;
  logic signed [W-1:0] dly_q, dly_d;
  logic                valid_q, valid_d;

  always_comb begin
    dout_d  = dout_q;
    dly_d   = dly_q;
    valid_d = en;
    if (en) begin
      dout_d = din - dly_q;
      dly_d  = din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dout_q  <= '0;
      dly_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      dly_q   <= dly_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;

endmodule

// File: rtl/decimate.sv
// Third-order CIC decimator for a 1-bit delta-sigma stream with a
// valid/ready output register. Define DECIMATE_ROUND_EN to round before the shift.
module decimate
  import decimate_pkg::*;
#(
  parameter int DECIM = DECIM_DEFAULT
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    bit_in,
  input  logic    bit_valid,
  output sample_t sample_o,
  output logic    sample_valid,
  input  logic    sample_ready,
  output logic    overrun
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int W     = cic_width(DECIM);
  localparam int S     = cic_shift(DECIM);

  localparam logic [LOG2D-1:0] CNT_LAST = LOG2D'(DECIM - 1);
  localparam logic signed [W:0] SAT_HI  = (W+1)'(SAT_MAX);
  localparam logic signed [W:0] SAT_LO  = (W+1)'(SAT_MIN);
  localparam sample_t           OUT_MAX = OUT_W'(SAT_MAX);
  localparam sample_t           OUT_MIN = OUT_W'(SAT_MIN);
`ifdef DECIMATE_ROUND_EN
  localparam logic signed [W:0] ROUND   = (W+1)'(1) << (S - 1);
`else
  localparam logic signed [W:0] ROUND   = '0;
`endif

  logic signed [W-1:0] x;
  logic signed [W-1:0] int1_q, int1_d, int2_q, int2_d, int3_q, int3_d;
  logic [LOG2D-1:0]    cnt_q, cnt_d;
  logic                strobe_q, strobe_d;
  logic [1:0]          warm_q, warm_d;
  sample_t             sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  logic signed [W-1:0] c1_out, c2_out, c3_out;
  logic                c1_valid, c2_valid, c3_valid;
  logic signed [W:0]   comb_ext, rounded, shifted;
  sample_t             sat_val;
  logic                load;

  assign x = bit_in ? W'(1) : '1;

  // Integrators chain on the freshly updated values; wrap modulo 2^W is harmless for a CIC.
  always_comb begin
    int1_d   = int1_q;
    int2_d   = int2_q;
    int3_d   = int3_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (bit_valid) begin
      int1_d   = int1_q + x;
      int2_d   = int2_q + int1_d;
      int3_d   = int3_q + int2_d;
      cnt_d    = cnt_q + LOG2D'(1);
      strobe_d = (cnt_q == CNT_LAST);
    end
  end

  decimate_comb #(.W(W)) u_comb1 (
    .clock(clock), .reset(reset), .en(strobe_q), .din(int3_q),
    .dout(c1_out), .valid(c1_valid)
  );

  decimate_comb #(.W(W)) u_comb2 (
    .clock(clock), .reset(reset), .en(c1_valid), .din(c1_out),
    .dout(c2_out), .valid(c2_valid)
  );

  decimate_comb #(.W(W)) u_comb3 (
    .clock(clock), .reset(reset), .en(c2_valid), .din(c2_out),
    .dout(c3_out), .valid(c3_valid)
  );

  // One guard bit so rounding the most positive comb value cannot overflow.
  always_comb begin
    comb_ext = {c3_out[W-1], c3_out};
    rounded  = comb_ext + ROUND;
    shifted  = rounded >>> S;
    if (shifted > SAT_HI) begin
      sat_val = OUT_MAX;
    end else if (shifted < SAT_LO) begin
      sat_val = OUT_MIN;
    end else begin
      sat_val = shifted[OUT_W-1:0];
    end
  end

  always_comb begin
    warm_d    = warm_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    load      = c3_valid && (warm_q == 2'd3);
    if (c3_valid && (warm_q != 2'd3)) begin
      warm_d = warm_q + 2'd1;
    end
    if (load) begin
      sample_d = sat_val;
      valid_d  = 1'b1;
      if (valid_q && !sample_ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      int1_q    <= '0;
      int2_q    <= '0;
      int3_q    <= '0;
      cnt_q     <= '0;
      strobe_q  <= 1'b0;
      warm_q    <= 2'd0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      int1_q    <= int1_d;
      int2_q    <= int2_d;
      int3_q    <= int3_d;
      cnt_q     <= cnt_d;
      strobe_q  <= strobe_d;
      warm_q    <= warm_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_o     = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule
